// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for seq_divider.
// The requester (ALU controller or bench) uses the master modport; the divider uses slave.
interface seq_divider_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, divByZero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, divByZero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// The trial subtract is R + ~divisor + 1; carry-out 1 means no borrow, matching the ALU add/sub path.
// Optional macro DIV_BY_ZERO_DETECT_EN: a zero divisor finishes in one cycle and raises divByZero.
// Without it, divByZero is tied low and a zero divisor runs the full algorithm
// (quotient all ones, remainder = dividend).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;          // dividend, shifted out MSB first
  logic [WIDTH-1:0] b_q;          // latched divisor
  logic [WIDTH:0]   r_q;          // partial remainder, one guard bit
  logic [WIDTH-1:0] q_q;          // quotient being assembled
  logic [CW-1:0]    cnt_q;        // iterations left
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
`ifdef DIV_BY_ZERO_DETECT_EN
  logic             dbz_q;
`endif

  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;

  // One restoring iteration: shift in next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    r_shift   = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
    trial     = {1'b0, r_shift} + {1'b0, ~{1'b0, b_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow = trial[WIDTH+1];
    r_d       = no_borrow ? trial[WIDTH:0] : r_shift;
    q_d       = {q_q[WIDTH-2:0], no_borrow};
  end

  // Control FSM with registered outputs; a start in DONE is accepted like one in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q   <= bus.dividend;
            b_q   <= bus.divisor;
            r_q   <= '0;
            q_q   <= '0;
            cnt_q <= CW'(WIDTH);
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_q <= 1'b0;
            if (bus.divisor == '0) begin
              // Short-circuit: report the natural result immediately.
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
`else
            busy_q  <= 1'b1;
            state_q <= RUN;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q << 1;
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            quotient_q  <= q_d;
            remainder_q <= r_d[WIDTH-1:0];
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
`ifdef DIV_BY_ZERO_DETECT_EN
  assign bus.divByZero = dbz_q;
`else
  assign bus.divByZero = 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_seq_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", int'(bus.quotient), int'(e.q));
        chk("remainder", int'(bus.remainder), int'(e.r));
        chk("divByZero", int'(bus.divByZero), int'(e.dbz));
        chk("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  // Issue an operation, push its expected result, and check busy/done timing.
  // repulse: drive a second start (7/2) while busy; it must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input bit repulse);
    exp_t e;
    bit   short_dbz;
`ifdef DIV_BY_ZERO_DETECT_EN
    short_dbz = (b == '0);
`else
    short_dbz = 1'b0;
`endif
    e.q = eq; e.r = er; e.dbz = short_dbz;
    exp_q.push_back(e);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;  // edge k
    bus.start = 1'b0;
    if (short_dbz) begin
      chk("dbz_busy_k", int'(bus.busy), 0);
      chk("dbz_done_k", int'(bus.done), 1);
      return;
    end
    chk("busy_k", int'(bus.busy), 1);
    for (int i = 1; i < W; i++) begin
      if (repulse && i == 1) begin
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("busy_run", int'(bus.busy), 1);
      chk("done_run", int'(bus.done), 0);
    end
    @(posedge clk); #1;  // edge k+WIDTH
    chk("done_edge", int'(bus.done), 1);
    chk("busy_edge", int'(bus.busy), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_quot"}, int'(bus.quotient), 0);
    chk({tag, "_rem"}, int'(bus.remainder), 0);
    chk({tag, "_dbz"}, int'(bus.divByZero), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    chk_reset_outputs("reset");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_done", int'(bus.done), 0);
      chk("idle_quot", int'(bus.quotient), 0);
    end

    run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(bus.done), 0);
    run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run_op(4'd2, 4'd7, 4'd0, 4'd2, 1'b0);
    run_op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    run_op(4'd8, 4'd3, 4'd2, 4'd2, 1'b0);
    run_op(4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    run_op(4'd9, 4'd0, 4'd15, 4'd9, 1'b0);
    @(posedge clk); #1;
    chk("dbz_clears_busy", int'(bus.busy), 0);

    // Start during busy is ignored; back-to-back start in the DONE cycle is accepted.
    run_op(4'd12, 4'd5, 4'd2, 4'd2, 1'b1);
    run_op(4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
    @(posedge clk); #1;

    // Reset mid-operation: abort, no done for the aborted request.
    bus.dividend = 4'd14; bus.divisor = 4'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", int'(bus.done), 0);
    end
    run_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
